// File: rtl/noc_pkg.sv
// Shared NoC constants and helpers for the injection arbiter and its round-robin core.
package noc_pkg;

   localparam int unsigned REQ_FLIT_W = 12;
   localparam int unsigned NOC_PORTS  = 4;
   localparam int unsigned GID_W      = $clog2(8);

   // Next round-robin pointer after a grant to idx, wrapping at n.
   function automatic logic [GID_W-1:0] rr_next(input logic [GID_W-1:0] idx, input int unsigned n);
      if (32'(idx) + 32'd1 >= n) begin
         return '0;
      end
      return idx + GID_W'(1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest set request at or above ptr, else lowest overall.
module rr_arbiter
   import noc_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]     req,
   input  logic [GID_W-1:0] ptr,
   input  logic             enable,
   output logic [N-1:0]     gnt,
   output logic [GID_W-1:0] gnt_idx,
   output logic             any
);

   logic [N-1:0] upper;
   logic [N-1:0] masked;
   logic [N-1:0] cand;

   always_comb begin
      upper = '0;
      for (int i = 0; i < int'(N); i++) begin
         upper[i] = (GID_W'(i) >= ptr);
      end
      masked  = req & upper;
      cand    = (|masked) ? masked : req;
      gnt     = '0;
      gnt_idx = '0;
      any     = enable & (|req);
      // Scan downwards so the lowest candidate index wins.
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (enable && cand[i]) begin
            gnt     = '0;
            gnt[i]  = 1'b1;
            gnt_idx = GID_W'(i);
         end
      end
   end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Shares one router input port between N_SRC local sources, one flit per cycle, honouring full/almost_full.
module noc_inject_arbiter
   import noc_pkg::*;
#(
   parameter int unsigned N_SRC  = NOC_PORTS,
   parameter int unsigned FLIT_W = REQ_FLIT_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_SRC-1:0]        src_valid,
   input  logic [N_SRC*FLIT_W-1:0] src_data,
   output logic [N_SRC-1:0]        src_ready,
   input  logic                    full,
   input  logic                    almost_full,
   output logic                    write_out,
   output logic [FLIT_W-1:0]       data_out,
   output logic [GID_W-1:0]        grant_id
);

   logic [N_SRC-1:0]  hold_valid;
   logic [FLIT_W-1:0] hold_data [N_SRC];
   logic [GID_W-1:0]  ptr;

   logic              can_issue;
   logic [N_SRC-1:0]  gnt;
   logic [GID_W-1:0]  gnt_idx;
   logic              any;
   logic [FLIT_W-1:0] sel_data;

   assign src_ready = ~hold_valid & {N_SRC{~reset}};

   // An in-flight write already owns the last free slot when almost_full is set.
   assign can_issue = ~full & ~(almost_full & write_out);

   rr_arbiter #(.N(N_SRC)) u_rr (
      .req     (hold_valid),
      .ptr     (ptr),
      .enable  (can_issue),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (gnt[i]) begin
            sel_data = sel_data | hold_data[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_valid <= '0;
         for (int i = 0; i < int'(N_SRC); i++) begin
            hold_data[i] <= '0;
         end
         ptr       <= '0;
         write_out <= 1'b0;
         data_out  <= '0;
         grant_id  <= '0;
      end else begin
         for (int i = 0; i < int'(N_SRC); i++) begin
            if (src_valid[i] && src_ready[i]) begin
               hold_valid[i] <= 1'b1;
               hold_data[i]  <= src_data[i*FLIT_W +: FLIT_W];
            end else if (gnt[i]) begin
               hold_valid[i] <= 1'b0;
            end
         end
         write_out <= any;
         if (any) begin
            data_out <= sel_data;
            grant_id <= gnt_idx;
            ptr      <= rr_next(gnt_idx, N_SRC);
         end
      end
   end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Scoreboard bench for noc_inject_arbiter: expected grants queued at stimulus, popped on each write_out.
module tb_noc_inject_arbiter;
   import noc_pkg::*;

   localparam int unsigned N = 4;
   localparam int unsigned W = 12;

   typedef struct packed {
      logic [GID_W-1:0] gid;
      logic [W-1:0]     data;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [N-1:0]     src_valid = '0;
   logic [N*W-1:0]   src_data = '0;
   logic [N-1:0]     src_ready;
   logic             full = 1'b0;
   logic             almost_full = 1'b0;
   logic             write_out;
   logic [W-1:0]     data_out;
   logic [GID_W-1:0] grant_id;

   exp_t       exp_q[$];
   logic [W-1:0] d [N];
   int         n_checks = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   noc_inject_arbiter #(.N_SRC(N), .FLIT_W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .src_ready   (src_ready),
      .full        (full),
      .almost_full (almost_full),
      .write_out   (write_out),
      .data_out    (data_out),
      .grant_id    (grant_id)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Advance to the next falling edge and score any write presented there.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (write_out === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(grant_id), 32'hffff_ffff);
         end else begin
            e = exp_q.pop_front();
            check("grant_id", 32'(grant_id), 32'(e.gid));
            check("data_out", 32'(data_out), 32'(e.data));
         end
      end
   endtask

   task automatic rand_data();
      for (int i = 0; i < int'(N); i++) d[i] = W'($urandom);
   endtask

   task automatic expect_src(input int i);
      exp_t e;
      e.gid  = GID_W'(i);
      e.data = d[i];
      exp_q.push_back(e);
   endtask

   task automatic load(input logic [N-1:0] m);
      src_data  = {d[3], d[2], d[1], d[0]};
      src_valid = m;
      step();
      src_valid = '0;
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
      check(tag, 32'(exp_q.size()), 32'd0);
      for (int k = 0; k < 3; k++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      full = 1'b0;
      almost_full = 1'b0;
      src_valid = '0;
      exp_q.delete();
      step();
      step();
      check("rst_write_out", 32'(write_out), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_src_ready", 32'(src_ready), 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < int'(N); i++) d[i] = '0;

      // Single source: minimum latency of two cycles.
      do_reset();
      step();
      check("single_ready_before", 32'(src_ready), 32'hf);
      rand_data();
      d[2] = 12'h0A5;
      expect_src(2);
      load(4'b0100);
      check("single_ready_held", 32'(src_ready[2]), 32'd0);
      check("single_no_early_wr", 32'(write_out), 32'd0);
      step();
      check("single_wr", 32'(write_out), 32'd1);
      drain("single_drain");

      // Four-way contention from ptr 0, back-to-back writes.
      do_reset();
      rand_data();
      for (int i = 0; i < 4; i++) expect_src(i);
      load(4'b1111);
      for (int k = 0; k < 4; k++) begin
         step();
         check("fourway_wr", 32'(write_out), 32'd1);
      end
      drain("fourway_drain");
      rand_data();
      expect_src(0);
      expect_src(1);
      load(4'b0011);
      drain("fourway_ptr0");

      // Rotation: ptr at 3 grants 3 before 0 and leaves ptr at 1.
      do_reset();
      rand_data();
      expect_src(2);
      load(4'b0100);
      drain("rot_setup");
      rand_data();
      expect_src(3);
      expect_src(0);
      load(4'b1001);
      drain("rot_wrap");
      rand_data();
      expect_src(1);
      expect_src(0);
      load(4'b0011);
      drain("rot_ptr1");

      // Full stall: nothing issues while full, then both flits exactly once.
      do_reset();
      full = 1'b1;
      rand_data();
      expect_src(0);
      expect_src(1);
      load(4'b0011);
      for (int k = 0; k < 5; k++) begin
         check("stall_no_wr", 32'(write_out), 32'd0);
         step();
      end
      check("stall_no_wr_end", 32'(write_out), 32'd0);
      full = 1'b0;
      step();
      check("stall_release0", 32'(write_out), 32'd1);
      step();
      check("stall_release1", 32'(write_out), 32'd1);
      drain("stall_drain");

      // Almost_full with a write in flight blocks the next issue.
      do_reset();
      rand_data();
      expect_src(0);
      expect_src(1);
      load(4'b0011);
      step();
      check("af_first_wr", 32'(write_out), 32'd1);
      almost_full = 1'b1;
      step();
      check("af_blocked", 32'(write_out), 32'd0);
      almost_full = 1'b0;
      step();
      check("af_resume", 32'(write_out), 32'd1);
      drain("af_drain");

      // Reset mid-operation discards held flits and the pending write.
      do_reset();
      rand_data();
      expect_src(0);
      load(4'b0111);
      step();
      check("midrst_wr_before", 32'(write_out), 32'd1);
      reset = 1'b1;
      exp_q.delete();
      step();
      check("midrst_write_out", 32'(write_out), 32'd0);
      check("midrst_data_out", 32'(data_out), 32'd0);
      check("midrst_grant_id", 32'(grant_id), 32'd0);
      check("midrst_src_ready", 32'(src_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("midrst_ready_after", 32'(src_ready), 32'hf);
      for (int k = 0; k < 4; k++) begin
         step();
         check("midrst_no_wr", 32'(write_out), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
